// File: rtl/mmio_unit.sv
// Memory-mapped I/O responder on the data-memory port: switch input, LED output,
// free-running cycle counter and sticky halt status, all served with one-cycle load latency.
module mmio_unit #(
    parameter logic [31:0] BASE    = 32'h0000_0100,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic        sysclk,
    input  logic        rstd,
    input  logic [7:0]  sw,
    input  logic [5:0]  op_w,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] rdata,
    output logic        hit,
    output logic [7:0]  led,
    output logic [31:0] count,
    output logic        halted
);

    logic [7:0]  sw_meta_reg;
    logic [7:0]  sw_sync_reg;
    logic [7:0]  led_reg;
    logic [31:0] count_reg;
    logic [31:0] rdata_reg;
    logic        hit_reg;
    logic        halted_reg;

    // One select line per register; exact 32-bit compare so misaligned addresses miss.
    logic [3:0]  sel;
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_decode
            assign sel[gi] = (mem_addr == (BASE + 32'(4 * gi)));
        end
    endgenerate

    logic        mapped;
    logic        halt_now;
    logic [31:0] read_next;

    assign mapped   = |sel;
    assign halt_now = (op_w == HALT_OP);

    always_comb begin
        read_next = 32'd0;
        if (sel[0]) read_next = {24'd0, sw_sync_reg};
        if (sel[1]) read_next = {24'd0, led_reg};
        if (sel[2]) read_next = count_reg;
        if (sel[3]) read_next = {31'd0, halted_reg};
    end

    always_ff @(posedge sysclk) begin
        if (!rstd) sw_meta_reg <= 8'd0;
        else       sw_meta_reg <= sw;
    end

    always_ff @(posedge sysclk) begin
        if (!rstd) sw_sync_reg <= 8'd0;
        else       sw_sync_reg <= sw_meta_reg;
    end

    // A store in the halt cycle still lands because halted_reg is not yet set.
    always_ff @(posedge sysclk) begin
        if (!rstd)                                 led_reg <= 8'd0;
        else if (mem_we && sel[1] && !halted_reg) led_reg <= mem_wdata[7:0];
    end

    always_ff @(posedge sysclk) begin
        if (!rstd)                          count_reg <= 32'd0;
        else if (!halted_reg && !halt_now) count_reg <= count_reg + 32'd1;
    end

    always_ff @(posedge sysclk) begin
        if (!rstd)        halted_reg <= 1'b0;
        else if (halt_now) halted_reg <= 1'b1;
    end

    // Load data reflects pre-edge state, giving read-before-write on LED.
    always_ff @(posedge sysclk) begin
        if (!rstd)       rdata_reg <= 32'd0;
        else if (mem_re) rdata_reg <= mapped ? read_next : 32'd0;
    end

    always_ff @(posedge sysclk) begin
        if (!rstd) hit_reg <= 1'b0;
        else       hit_reg <= mem_re && mapped;
    end

    assign rdata  = rdata_reg;
    assign hit    = hit_reg;
    assign led    = led_reg;
    assign count  = count_reg;
    assign halted = halted_reg;

endmodule

// File: tb/tb_mmio_unit.sv
// Directed bench for mmio_unit: one task per feature, inline checks, one summary line.
module tb_mmio_unit;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        sysclk = 1'b0;
    logic        rstd;
    logic [7:0]  sw;
    logic [5:0]  op_w;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] rdata;
    logic        hit;
    logic [7:0]  led;
    logic [31:0] count;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    mmio_unit dut (
        .sysclk    (sysclk),
        .rstd      (rstd),
        .sw        (sw),
        .op_w      (op_w),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .rdata     (rdata),
        .hit       (hit),
        .led       (led),
        .count     (count),
        .halted    (halted)
    );

    always #5 sysclk = ~sysclk;

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic idle_bus();
        mem_we = 1'b0;
        mem_re = 1'b0;
        mem_addr = 32'd0;
        mem_wdata = 32'd0;
    endtask

    task automatic test_reset();
        rstd = 1'b0; sw = 8'hFF; op_w = 6'd0;
        idle_bus();
        step(); step();
        checks++; if (led !== 8'd0) begin failures++; $display("FAIL reset_led got=%h exp=00", led); end
        checks++; if (count !== 32'd0) begin failures++; $display("FAIL reset_count got=%h exp=0", count); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", hit); end
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        rstd = 1'b1;
        repeat (5) step();
        checks++; if (count !== 32'd5) begin failures++; $display("FAIL reset_count5 got=%0d exp=5", count); end
        $display("test_reset: count after release=%0d", count);
    endtask

    task automatic test_switch_sync();
        sw = 8'hA5;
        step(); step();
        mem_re = 1'b1; mem_addr = BASE;
        step();
        idle_bus();
        checks++; if (rdata !== 32'h0000_00A5) begin failures++; $display("FAIL sw_read got=%h exp=000000a5", rdata); end
        checks++; if (hit !== 1'b1) begin failures++; $display("FAIL sw_hit got=%b exp=1", hit); end
        step();
        checks++; if (hit !== 1'b0) begin failures++; $display("FAIL sw_hit_drop got=%b exp=0", hit); end
        checks++; if (rdata !== 32'h0000_00A5) begin failures++; $display("FAIL sw_rdata_hold got=%h exp=000000a5", rdata); end
        sw = 8'h5A;
        step();
        mem_re = 1'b1; mem_addr = BASE;
        step();
        idle_bus();
        checks++; if (rdata !== 32'h0000_00A5) begin failures++; $display("FAIL sw_early_read got=%h exp=000000a5", rdata); end
        $display("test_switch_sync: early read rdata=%h", rdata);
    endtask

    task automatic test_led();
        mem_we = 1'b1; mem_addr = BASE + 32'h4; mem_wdata = 32'h1234_5678;
        step();
        idle_bus();
        checks++; if (led !== 8'h78) begin failures++; $display("FAIL led_store got=%h exp=78", led); end
        mem_we = 1'b1; mem_re = 1'b1; mem_addr = BASE + 32'h4; mem_wdata = 32'h0000_003C;
        step();
        idle_bus();
        checks++; if (rdata !== 32'h0000_0078) begin failures++; $display("FAIL led_rbw_rdata got=%h exp=00000078", rdata); end
        checks++; if (led !== 8'h3C) begin failures++; $display("FAIL led_rbw_led got=%h exp=3c", led); end
        checks++; if (hit !== 1'b1) begin failures++; $display("FAIL led_rbw_hit got=%b exp=1", hit); end
        mem_we = 1'b1; mem_addr = BASE; mem_wdata = 32'h0000_00FF;
        step();
        idle_bus();
        checks++; if (led !== 8'h3C) begin failures++; $display("FAIL led_ro_store got=%h exp=3c", led); end
        $display("test_led: led=%h", led);
    endtask

    task automatic test_unmapped();
        logic [31:0] c0;
        mem_re = 1'b1; mem_addr = BASE + 32'h10;
        step();
        idle_bus();
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL unmap10_rdata got=%h exp=0", rdata); end
        checks++; if (hit !== 1'b0) begin failures++; $display("FAIL unmap10_hit got=%b exp=0", hit); end
        mem_re = 1'b1; mem_addr = BASE + 32'h4;
        step();
        mem_re = 1'b1; mem_addr = BASE + 32'h2;
        step();
        idle_bus();
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL unmap02_rdata got=%h exp=0", rdata); end
        checks++; if (hit !== 1'b0) begin failures++; $display("FAIL unmap02_hit got=%b exp=0", hit); end
        c0 = count;
        mem_we = 1'b1; mem_addr = BASE + 32'h8; mem_wdata = 32'd0;
        step();
        idle_bus();
        checks++; if (count !== c0 + 32'd1) begin failures++; $display("FAIL cnt_ro_store got=%h exp=%h", count, c0 + 32'd1); end
        c0 = count;
        mem_re = 1'b1; mem_addr = BASE + 32'h8;
        step();
        idle_bus();
        checks++; if (rdata !== c0) begin failures++; $display("FAIL cnt_read got=%h exp=%h", rdata, c0); end
        $display("test_unmapped: count read=%h", rdata);
    endtask

    task automatic test_back_to_back();
        sw = 8'hC3;
        step(); step();
        mem_re = 1'b1; mem_addr = BASE;
        step();
        checks++; if (rdata !== 32'h0000_00C3) begin failures++; $display("FAIL b2b_sw got=%h exp=000000c3", rdata); end
        mem_addr = BASE + 32'h4;
        step();
        checks++; if (rdata !== 32'h0000_003C) begin failures++; $display("FAIL b2b_led got=%h exp=0000003c", rdata); end
        mem_addr = BASE + 32'hC;
        step();
        idle_bus();
        checks++; if (rdata !== 32'd0 || hit !== 1'b1) begin failures++; $display("FAIL b2b_stat got=%h/%b exp=0/1", rdata, hit); end
        $display("test_back_to_back: stat=%h", rdata);
    endtask

    task automatic test_halt();
        rstd = 1'b0; op_w = 6'd0;
        idle_bus();
        step();
        rstd = 1'b1;
        repeat (20) step();
        checks++; if (count !== 32'd20) begin failures++; $display("FAIL halt_pre_count got=%0d exp=20", count); end
        op_w = 6'h3F;
        mem_we = 1'b1; mem_addr = BASE + 32'h4; mem_wdata = 32'h0000_005A;
        step();
        idle_bus();
        op_w = 6'd0;
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag got=%b exp=1", halted); end
        checks++; if (count !== 32'd20) begin failures++; $display("FAIL halt_count got=%0d exp=20", count); end
        checks++; if (led !== 8'h5A) begin failures++; $display("FAIL halt_cycle_store got=%h exp=5a", led); end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (count !== 32'd20) begin failures++; $display("FAIL halt_frozen[%0d] got=%0d exp=20", i, count); end
        end
        mem_we = 1'b1; mem_addr = BASE + 32'h4; mem_wdata = 32'h0000_00FF;
        step();
        idle_bus();
        checks++; if (led !== 8'h5A) begin failures++; $display("FAIL halt_store got=%h exp=5a", led); end
        mem_re = 1'b1; mem_addr = BASE + 32'hC;
        step();
        idle_bus();
        checks++; if (rdata !== 32'd1) begin failures++; $display("FAIL halt_stat got=%h exp=1", rdata); end
        checks++; if (hit !== 1'b1) begin failures++; $display("FAIL halt_stat_hit got=%b exp=1", hit); end
        rstd = 1'b0;
        step();
        checks++; if (halted !== 1'b0 || count !== 32'd0 || led !== 8'd0 || rdata !== 32'd0 || hit !== 1'b0) begin
            failures++;
            $display("FAIL halt_reset got=h%b c%h l%h r%h t%b exp=all0", halted, count, led, rdata, hit);
        end
        rstd = 1'b1;
        step();
        checks++; if (count !== 32'd1) begin failures++; $display("FAIL halt_restart got=%0d exp=1", count); end
        $display("test_halt: restarted count=%0d", count);
    endtask

    task automatic test_wrap();
        op_w = 6'd0;
        dut.count_reg = 32'hFFFF_FFFE;
        step();
        checks++; if (count !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap0 got=%h exp=ffffffff", count); end
        step();
        checks++; if (count !== 32'd0) begin failures++; $display("FAIL wrap1 got=%h exp=0", count); end
        step();
        checks++; if (count !== 32'd1) begin failures++; $display("FAIL wrap2 got=%h exp=1", count); end
        $display("test_wrap: count=%h", count);
    endtask

    initial begin
        test_reset();
        test_switch_sync();
        test_led();
        test_unmapped();
        test_back_to_back();
        test_halt();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmio_unit.md
Name: mmio_unit

Overview:
- Memory-mapped I/O responder inside the pipelined processor; serves the board-side I/O that a bench drives and watches.
- Synchronizes the 8 switches into a readable register.
- Holds the LED output register, written by store instructions.
- Runs the cycle counter and latches the halt condition (writeback opcode all-ones).
- Sits on the data-memory port beside the data RAM; the MEM stage muxes rdata when hit is high.

Parameters:
- BASE, 32'h0000_0100, byte address of the first I/O register; all four registers are word-aligned at offsets 0x0, 0x4, 0x8, 0xC.
- HALT_OP, 6'b111111, writeback-stage opcode that stops the machine.

Ports:
- sysclk  in  1  system clock; all state updates on the rising edge.
- rstd  in  1  reset; synchronous and active-low.
- sw  in  8  raw board switches; asynchronous to sysclk.
- op_w  in  6  opcode of the instruction in the writeback stage.
- mem_addr  in  32  byte address from the MEM stage.
- mem_wdata  in  32  store data.
- mem_we  in  1  store strobe, one cycle per store.
- mem_re  in  1  load strobe, one cycle per load.
- rdata  out  32  registered load data.
- hit  out  1  registered; high the cycle after a load to a mapped address.
- led  out  8  LED register.
- count  out  32  cycle counter.
- halted  out  1  sticky halt flag.

Behaviour:
- Reset: on a rising edge with rstd=0, clear rdata, hit, led, count, halted and both synchronizer stages to 0. Reset applied mid-operation, including after halt, fully restarts the block.
- Switch path: sw passes through 2 flops (sw_meta, then sw_sync). A change settled before edge k is in sw_sync after edge k+1.
- Register map (addresses compared on all 32 bits; misaligned addresses are unmapped):
  - BASE+0x0 SW: read-only, returns {24'b0, sw_sync}.
  - BASE+0x4 LED: read/write, returns {24'b0, led}.
  - BASE+0x8 CNT: read-only, returns count.
  - BASE+0xC STAT: read-only, returns {31'b0, halted}.
- Loads: mem_re in cycle N gives rdata and hit at edge N+1 (1-cycle latency), holding until the next load.
  - Unmapped load: rdata=0, hit=0.
  - With mem_re=0: rdata holds and hit drops to 0.
- Stores: mem_we to LED with halted=0 loads led <= mem_wdata[7:0] at that edge.
  - Stores to read-only or unmapped addresses are ignored.
  - All stores are ignored once halted=1.
- Same-cycle load and store to LED is read-before-write: rdata returns the old led, and led takes the new value at the same edge.
- Counter: count increments by 1 every edge while halted=0 and op_w!=HALT_OP. It wraps from 32'hFFFF_FFFF to 0 without a flag.
- Halt: at the first edge with op_w==HALT_OP, halted <= 1 and count does not increment. After that, count and led are frozen and loads still work.
- Halt with simultaneous store: a store in the halt cycle itself is still performed, because halted is still 0 in that cycle.
- Single always block per register; no latches; no combinational path from inputs to outputs.

Test Plan:
- Reset: hold rstd=0 for 2 edges with sw=8'hFF and op_w=0 -> led=0, count=0, halted=0, hit=0, rdata=0; release and after 5 edges count=5.
- Switch sync: set sw=8'hA5, wait 2 edges, load BASE+0x0 -> next edge rdata=32'h0000_00A5, hit=1. A load issued 1 edge after the sw change returns the old value.
- LED: store 32'h1234_5678 to BASE+0x4 -> led=8'h78. Same-cycle load and store of 8'h3C to LED -> rdata=32'h78, then led=8'h3C. Store to BASE+0x0 -> led unchanged.
- Unmapped and read-only: load BASE+0x10 and BASE+0x2 -> rdata=0, hit=0. Store to BASE+0x8 -> count unaffected.
- Halt: op_w=6'h3F at the edge where count=20 -> halted=1, count stays 20 for 10 further edges. Store 8'hFF to LED after halt -> led unchanged. Load BASE+0xC -> rdata=1. Then rstd=0 -> all cleared.
- Wrap: force count to 32'hFFFF_FFFE, run 3 edges -> 32'hFFFF_FFFF, 0, 1.
